// File: rtl/gsim_sweep_sched.sv
// Gauss-Seidel sweep sequencer: loads b, issues one element update per PIPE_LAT slot, then streams results.
// Optional GSIM_CONV_EN: ends the run early once a full sweep reports every element converged.
module gsim_sweep_sched #(
   parameter int N        = 16,
   parameter int IDX_W    = 4,
   parameter int PIPE_LAT = 8,
   parameter int MAX_ITER = 85,
   parameter int ITER_W   = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_en,
   input  logic              dp_conv,
   output logic              load_we,
   output logic [IDX_W-1:0]  load_idx,
   output logic              dp_issue,
   output logic              dp_wb,
   output logic [IDX_W-1:0]  dp_idx,
   output logic              out_valid,
   output logic [IDX_W-1:0]  rd_idx,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done
);
   localparam int PH_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PIPE_LAT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
   localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(MAX_ITER);

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_ITER = 2'd1,
      S_OUT  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_r;
   logic [IDX_W-1:0]  b_cnt_r;
   logic [IDX_W-1:0]  dp_idx_r;
   logic [IDX_W-1:0]  rd_cnt_r;
   logic [PH_W-1:0]   phase_r;
   logic [ITER_W-1:0] iter_cnt_r;
   logic              issue_r;
   logic              wb_r;
   logic              out_valid_r;
   logic              busy_r;
   logic              done_r;
   logic [ITER_W-1:0] iter_next_s;
   logic              sweep_conv_s;
   logic              exit_s;

`ifdef GSIM_CONV_EN
   logic conv_miss_r;

   // Sweep-wide "some element not converged" flag, cleared when element 0 is issued
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conv_miss_r <= 1'b0;
      end else if (state_r == S_ITER && issue_r && dp_idx_r == {IDX_W{1'b0}}) begin
         conv_miss_r <= 1'b0;
      end else if (state_r == S_ITER && wb_r && !dp_conv) begin
         conv_miss_r <= 1'b1;
      end else begin
         conv_miss_r <= conv_miss_r;
      end
   end

   // The writeback in flight counts toward the sweep's verdict
   assign sweep_conv_s = !(conv_miss_r || !dp_conv);
`else
   assign sweep_conv_s = dp_conv & 1'b0;
`endif

   assign iter_next_s = iter_cnt_r + {{(ITER_W-1){1'b0}}, 1'b1};
   assign exit_s      = (iter_next_s == ITER_MAX) || sweep_conv_s;

   // Main sequencer FSM; every datapath strobe is registered one cycle ahead of its slot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= S_LOAD;
         b_cnt_r     <= {IDX_W{1'b0}};
         dp_idx_r    <= {IDX_W{1'b0}};
         rd_cnt_r    <= {IDX_W{1'b0}};
         phase_r     <= {PH_W{1'b0}};
         iter_cnt_r  <= {ITER_W{1'b0}};
         issue_r     <= 1'b0;
         wb_r        <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            S_LOAD: begin
               if (in_en) begin
                  b_cnt_r <= b_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
                  if (b_cnt_r == IDX_LAST) begin
                     state_r  <= S_ITER;
                     phase_r  <= {PH_W{1'b0}};
                     dp_idx_r <= {IDX_W{1'b0}};
                     issue_r  <= 1'b1;
                     busy_r   <= 1'b1;
                  end
               end
            end
            S_ITER: begin
               if (phase_r == PH_LAST) begin
                  phase_r  <= {PH_W{1'b0}};
                  wb_r     <= 1'b0;
                  dp_idx_r <= dp_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                  if (dp_idx_r == IDX_LAST) begin
                     iter_cnt_r <= iter_next_s;
                     if (exit_s) begin
                        state_r     <= S_OUT;
                        issue_r     <= 1'b0;
                        out_valid_r <= 1'b1;
                        rd_cnt_r    <= {IDX_W{1'b0}};
                     end else begin
                        issue_r <= 1'b1;
                     end
                  end else begin
                     issue_r <= 1'b1;
                  end
               end else begin
                  phase_r <= phase_r + {{(PH_W-1){1'b0}}, 1'b1};
                  issue_r <= 1'b0;
                  wb_r    <= ((phase_r + {{(PH_W-1){1'b0}}, 1'b1}) == PH_LAST);
               end
            end
            S_OUT: begin
               rd_cnt_r <= rd_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
               if (rd_cnt_r == IDX_LAST) begin
                  state_r     <= S_DONE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
                  done_r      <= 1'b1;
               end
            end
            S_DONE: begin
               done_r <= 1'b1;
            end
            default: begin
               state_r <= S_LOAD;
            end
         endcase
      end
   end

   assign load_we   = (state_r == S_LOAD) && in_en;
   assign load_idx  = b_cnt_r;
   assign dp_issue  = issue_r;
   assign dp_wb     = wb_r;
   assign dp_idx    = dp_idx_r;
   assign out_valid = out_valid_r;
   assign rd_idx    = rd_cnt_r;
   assign iter_cnt  = iter_cnt_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: tb/tb_gsim_sweep_sched.sv
// Scoreboard bench for gsim_sweep_sched: the expected event timeline is queued when the load completes
// and matched cycle by cycle against the DUT strobes.
module tb_gsim_sweep_sched;
   localparam int N     = 16;
   localparam int SLOT  = 8;
   localparam int SWEEP = N * SLOT;
`ifdef GSIM_CONV_EN
   localparam int EXP_SW = 5;
`else
   localparam int EXP_SW = 85;
`endif

   typedef struct {
      int cyc;
      int idx;
      int it;
   } ev_t;

   logic       clk;
   logic       reset;
   logic       in_en;
   logic       dp_conv;
   logic       load_we;
   logic [3:0] load_idx;
   logic       dp_issue;
   logic       dp_wb;
   logic [3:0] dp_idx;
   logic       out_valid;
   logic [3:0] rd_idx;
   logic [6:0] iter_cnt;
   logic       busy;
   logic       done;

   int  cyc    = 0;
   int  t0     = -1;
   int  t_end  = 0;
   int  n_chk  = 0;
   int  n_pass = 0;
   int  load_q[$];
   ev_t iss_q[$];
   ev_t wb_q[$];
   ev_t out_q[$];
   bit  exp_ld;
   bit  exp_hit;
   ev_t ev;

   gsim_sweep_sched dut (
      .clk       (clk),
      .reset     (reset),
      .in_en     (in_en),
      .dp_conv   (dp_conv),
      .load_we   (load_we),
      .load_idx  (load_idx),
      .dp_issue  (dp_issue),
      .dp_wb     (dp_wb),
      .dp_idx    (dp_idx),
      .out_valid (out_valid),
      .rd_idx    (rd_idx),
      .iter_cnt  (iter_cnt),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index of the current clock period
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp_v);
      n_chk++;
      if (obs == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
   endtask

   function automatic void flush_queues();
      load_q.delete();
      iss_q.delete();
      wb_q.delete();
      out_q.delete();
   endfunction

   // Converged on every writeback of sweep 4; converged except element 9 in sweep 2
   function automatic logic conv_at(input int c);
      int rel;
      int s;
      int i;
      if (t0 < 0 || c < t0) return 1'b0;
      rel = c - t0;
      s   = rel / SWEEP;
      i   = (rel % SWEEP) / SLOT;
      return (s == 4) || (s == 2 && i != 9);
   endfunction

   task automatic load_all(input bit gap);
      for (int k = 0; k < N; k++) begin
         if (gap && k == 5) begin
            repeat (3) begin
               @(posedge clk); #1;
               in_en = 1'b0;
            end
         end
         @(posedge clk); #1;
         in_en   = 1'b1;
         dp_conv = 1'b0;
         load_q.push_back(k);
      end
      t0 = cyc + 1;
      for (int s = 0; s < EXP_SW; s++) begin
         for (int i = 0; i < N; i++) begin
            iss_q.push_back('{cyc: t0 + s * SWEEP + i * SLOT, idx: i, it: s});
            wb_q.push_back('{cyc: t0 + s * SWEEP + i * SLOT + SLOT - 1, idx: i, it: s});
         end
      end
      for (int r = 0; r < N; r++) out_q.push_back('{cyc: t0 + EXP_SW * SWEEP + r, idx: r, it: EXP_SW});
      t_end = t0 + EXP_SW * SWEEP + N;
   endtask

   task automatic run_to(input int t_stop, input bit toggle);
      while (cyc < t_stop) begin
         @(posedge clk); #1;
         in_en   = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
         dp_conv = conv_at(cyc);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_issue"}, int'(dp_issue), 0);
      check({tag, "_wb"}, int'(dp_wb), 0);
      check({tag, "_dp_idx"}, int'(dp_idx), 0);
      check({tag, "_load_idx"}, int'(load_idx), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_rd_idx"}, int'(rd_idx), 0);
      check({tag, "_iter_cnt"}, int'(iter_cnt), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   task automatic check_finished(input string tag);
      @(negedge clk);
      check({tag, "_done"}, int'(done), 1);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_out_valid"}, int'(out_valid), 0);
      check({tag, "_iter_cnt"}, int'(iter_cnt), EXP_SW);
      check({tag, "_events_left"}, iss_q.size() + wb_q.size() + out_q.size() + load_q.size(), 0);
   endtask

   // Scoreboard: every DUT strobe must match the head of its queue, and every queued event must occur
   always @(negedge clk) begin
      if (!reset) begin
         exp_ld = (load_q.size() > 0);
         if (in_en || load_we || exp_ld) begin
            check("load_we", int'(load_we), int'(exp_ld));
            if (exp_ld) check("load_idx", int'(load_idx), load_q.pop_front());
            else check("load_idx_hold", int'(load_idx), 0);
         end
         exp_hit = (iss_q.size() > 0) && (iss_q[0].cyc == cyc);
         if (dp_issue || exp_hit) begin
            check("dp_issue", int'(dp_issue), int'(exp_hit));
            if (exp_hit) begin
               ev = iss_q.pop_front();
               check("issue_idx", int'(dp_idx), ev.idx);
               check("issue_iter", int'(iter_cnt), ev.it);
               check("issue_busy", int'(busy), 1);
            end
         end
         exp_hit = (wb_q.size() > 0) && (wb_q[0].cyc == cyc);
         if (dp_wb || exp_hit) begin
            check("dp_wb", int'(dp_wb), int'(exp_hit));
            if (exp_hit) begin
               ev = wb_q.pop_front();
               check("wb_idx", int'(dp_idx), ev.idx);
               check("wb_iter", int'(iter_cnt), ev.it);
            end
         end
         exp_hit = (out_q.size() > 0) && (out_q[0].cyc == cyc);
         if (out_valid || exp_hit) begin
            check("out_valid", int'(out_valid), int'(exp_hit));
            if (exp_hit) begin
               ev = out_q.pop_front();
               check("rd_idx", int'(rd_idx), ev.idx);
               check("out_iter", int'(iter_cnt), ev.it);
               check("out_busy", int'(busy), 1);
               check("out_done", int'(done), 0);
            end
         end
      end
   end

   initial begin
      reset   = 1'b1;
      in_en   = 1'b0;
      dp_conv = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("rst");
      check("rst_load_we", int'(load_we), 0);
      reset = 1'b0;

      // Run A: gapped load, in_en noise during ITER/OUT/DONE
      load_all(1'b1);
      run_to(t_end + 6, 1'b1);
      check_finished("runA");

      // Run B: reset in the middle of sweep 3, slot 0, phase 4
      @(posedge clk); #1;
      in_en = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      flush_queues();
      t0    = -1;
      reset = 1'b0;
      load_all(1'b0);
      run_to(t0 + 3 * SWEEP + 4, 1'b0);
      check("pre_rst_iter_cnt", int'(iter_cnt), 3);
      check("pre_rst_busy", int'(busy), 1);
      #1;
      reset = 1'b1;
      #1;
      flush_queues();
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      reset = 1'b0;
      t0    = -1;

      // Run C: clean reload after the mid-run reset
      load_all(1'b0);
      run_to(t_end + 6, 1'b0);
      check_finished("runC");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
